// File: rtl/pipe_chain.sv
// pipe_chain: in-order back-end register chain (stage 0 = E, STAGES-1 = W)
// with per-stage hold/flush/bubble control, a source-register forwarding
// network and a retirement counter.
// Optional feature: define PIPE_FWD_EN to enable in-flight forwarding;
// otherwise operands always come from the register file.
module pipe_chain #(
  parameter int STAGES = 3,
  parameter int WIDTH  = 64,
  parameter int RADDR  = 5,
  parameter int NSRC   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [RADDR-1:0]        in_rd,
  input  logic                    in_we,
  input  logic                    bubble,
  input  logic [STAGES-1:0]       hold,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES-1:0]       st_valid,
  output logic [STAGES*WIDTH-1:0] st_data,
  output logic [STAGES*RADDR-1:0] st_rd,
  output logic [STAGES-1:0]       st_we,
  input  logic [STAGES*32-1:0]    st_result,
  input  logic [NSRC*RADDR-1:0]   fwd_ra,
  input  logic [NSRC*32-1:0]      fwd_rf,
  output logic [NSRC*32-1:0]      fwd_val,
  output logic [NSRC-1:0]         fwd_hit,
  output logic [31:0]             retired
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] frz;
  logic [STAGES-1:0] validQ;
  logic [STAGES-1:0] weQ;
  logic [WIDTH-1:0]  dataQ [STAGES];
  logic [RADDR-1:0]  rdQ   [STAGES];
  logic [31:0]       retCnt;
  logic              retire;
  logic [RADDR-1:0]  srcReg;
  logic              found;

  // A stage is frozen when it or any older stage holds
  always_comb begin
    frz       = '0;
    frz[LAST] = hold[LAST];
    for (int unsigned k = 1; k < STAGES; k++) begin
      frz[LAST-k] = hold[LAST-k] | frz[LAST-k+1];
    end
  end

  assign in_ready = ~frz[0] & ~bubble & ~flush[0];
  assign retire   = validQ[LAST] & ~hold[LAST] & ~flush[LAST];

  // Stage registers: flush > freeze > load/bubble/copy
  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= '0;
      weQ    <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        dataQ[i] <= '0;
        rdQ[i]   <= '0;
      end
    end else begin
      if (flush[0]) begin
        validQ[0] <= 1'b0;
        weQ[0]    <= 1'b0;
        dataQ[0]  <= '0;
        rdQ[0]    <= '0;
      end else if (!frz[0]) begin
        validQ[0] <= in_valid & ~bubble;
        weQ[0]    <= in_we;
        dataQ[0]  <= in_data;
        rdQ[0]    <= in_rd;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (flush[i]) begin
          validQ[i] <= 1'b0;
          weQ[i]    <= 1'b0;
          dataQ[i]  <= '0;
          rdQ[i]    <= '0;
        end else if (!frz[i]) begin
          if (hold[i-1]) begin
            validQ[i] <= 1'b0;
            weQ[i]    <= 1'b0;
            dataQ[i]  <= '0;
            rdQ[i]    <= '0;
          end else begin
            validQ[i] <= validQ[i-1];
            weQ[i]    <= weQ[i-1];
            dataQ[i]  <= dataQ[i-1];
            rdQ[i]    <= rdQ[i-1];
          end
        end
      end
    end
  end

  // Retirement counter, wraps at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      retCnt <= '0;
    end else if (retire) begin
      retCnt <= retCnt + 32'd1;
    end
  end

  assign retired  = retCnt;
  assign st_valid = validQ;
  assign st_we    = weQ;

  // Flatten per-stage payload and destination onto the packed output buses
  always_comb begin
    st_data = '0;
    st_rd   = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      st_data[i*WIDTH +: WIDTH] = dataQ[i];
      st_rd[i*RADDR +: RADDR]   = rdQ[i];
    end
  end

`ifndef PIPE_FWD_EN
  logic unusedResult;
  assign unusedResult = ^st_result;
`endif

  // Operand lookup: youngest matching in-flight stage wins, x0 reads as zero
  always_comb begin
    fwd_val = fwd_rf;
    fwd_hit = '0;
    srcReg  = '0;
    found   = 1'b0;
    for (int unsigned p = 0; p < NSRC; p++) begin
      srcReg = fwd_ra[p*RADDR +: RADDR];
      found  = 1'b0;
`ifdef PIPE_FWD_EN
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (!found && validQ[i] && weQ[i] && (rdQ[i] == srcReg)) begin
          fwd_val[p*32 +: 32] = st_result[i*32 +: 32];
          fwd_hit[p]          = 1'b1;
          found               = 1'b1;
        end
      end
`endif
      if (srcReg == '0) begin
        fwd_val[p*32 +: 32] = '0;
        fwd_hit[p]          = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed testbench for pipe_chain (STAGES=3, WIDTH=64, RADDR=5, NSRC=2).
// Forwarding expectations follow PIPE_FWD_EN as seen by this compilation.
module tb_pipe_chain;

  localparam int STAGES = 3;
  localparam int WIDTH  = 64;
  localparam int RADDR  = 5;
  localparam int NSRC   = 2;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic [RADDR-1:0]        in_rd;
  logic                    in_we;
  logic                    bubble;
  logic [STAGES-1:0]       hold;
  logic [STAGES-1:0]       flush;
  logic [STAGES-1:0]       st_valid;
  logic [STAGES*WIDTH-1:0] st_data;
  logic [STAGES*RADDR-1:0] st_rd;
  logic [STAGES-1:0]       st_we;
  logic [STAGES*32-1:0]    st_result;
  logic [NSRC*RADDR-1:0]   fwd_ra;
  logic [NSRC*32-1:0]      fwd_rf;
  logic [NSRC*32-1:0]      fwd_val;
  logic [NSRC-1:0]         fwd_hit;
  logic [31:0]             retired;

  int checks = 0;
  int errors = 0;

  pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .RADDR(RADDR), .NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_we(in_we), .bubble(bubble),
    .hold(hold), .flush(flush), .st_valid(st_valid), .st_data(st_data),
    .st_rd(st_rd), .st_we(st_we), .st_result(st_result), .fwd_ra(fwd_ra),
    .fwd_rf(fwd_rf), .fwd_val(fwd_val), .fwd_hit(fwd_hit), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [4:0] rd, input logic we);
    in_valid = 1'b1;
    in_data  = d;
    in_rd    = rd;
    in_we    = we;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] sd(input int i);
    return st_data[i*WIDTH +: WIDTH];
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_rd = '0; in_we = 1'b0;
    bubble = 1'b0; hold = '0; flush = '0; st_result = '0; fwd_ra = '0; fwd_rf = '0;
    step();
    step();
    check("rst_valid", st_valid, 0);
    check("rst_ret", retired, 0);
    check("rst_ready", in_ready, 1);
    reset = 1'b0;

    // back-to-back stream 1..5
    for (int e = 1; e <= 8; e++) begin
      in_valid = (e <= 5);
      in_data  = e;
      step();
      if (e >= 3 && e <= 7) begin
        check("t1_v2", st_valid[2], 1);
        check("t1_d2", sd(2), e - 2);
      end
      check("t1_ret", retired, (e > 3) ? e - 3 : 0);
    end
    in_valid = 1'b0;
    check("t1_v2_end", st_valid[2], 0);

    // full chain, hold[1] for two cycles
    push(11, 1, 1); push(12, 1, 1); push(13, 1, 1);
    hold = 3'b010; in_valid = 1'b1; in_data = 14; #1;
    check("t2_ready", in_ready, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("t2_d0", sd(0), 13);
      check("t2_d1", sd(1), 12);
      check("t2_v2", st_valid[2], 0);
      check("t2_ret", retired, 6);
    end
    hold = '0; #1;
    check("t2_ready1", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t2_d0b", sd(0), 14);
    check("t2_s2a", sd(2), 12);
    check("t2_ret2", retired, 6);
    step();
    check("t2_s2b", sd(2), 13);
    step();
    check("t2_s2c", sd(2), 14);
    step();
    check("t2_ret3", retired, 9);

    // bubble with a pending entry
    in_valid = 1'b1; in_data = 21; bubble = 1'b1; #1;
    check("t3_ready", in_ready, 0);
    step();
    check("t3_v0", st_valid[0], 0);
    bubble = 1'b0; #1;
    check("t3_ready1", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t3_v0b", st_valid[0], 1);
    check("t3_d0", sd(0), 21);
    step(); step(); step();
    check("t3_ret", retired, 10);

    // flush[1] together with hold[1]
    push(31, 1, 1); push(32, 1, 1); push(33, 1, 1);
    flush = 3'b010; hold = 3'b010;
    step();
    check("t4_v1", st_valid[1], 0);
    check("t4_v0", st_valid[0], 1);
    check("t4_d0", sd(0), 33);
    check("t4_v2", st_valid[2], 0);
    check("t4_ret", retired, 11);
    flush = '0; hold = '0;
    step(); step(); step();
    check("t4_ret2", retired, 12);

    // forwarding: stage0 rd5 we1, stage1 rd7 we1, stage2 rd5 we1
    push(41, 5, 1); push(42, 7, 1); push(43, 5, 1);
    st_result = {32'h0000BBBB, 32'h0000CCCC, 32'h0000AAAA};
    fwd_rf    = {32'h00002222, 32'h00001111};
    fwd_ra    = {5'd7, 5'd5}; #1;
    check("f_p0", fwd_val[31:0], FWD ? 32'hAAAA : 32'h1111);
    check("f_h0", fwd_hit[0], FWD);
    check("f_p1", fwd_val[63:32], FWD ? 32'hCCCC : 32'h2222);
    check("f_h1", fwd_hit[1], FWD);
    fwd_ra = {5'd9, 5'd0}; #1;
    check("f_zero", fwd_val[31:0], 0);
    check("f_zhit", fwd_hit[0], 0);
    check("f_miss", fwd_val[63:32], 32'h2222);
    check("f_mhit", fwd_hit[1], 0);
    push(44, 5, 1); push(45, 7, 1); push(46, 5, 0);
    check("f_ret", retired, 15);
    fwd_ra = {5'd0, 5'd5}; #1;
    check("f_we0", fwd_val[31:0], FWD ? 32'hBBBB : 32'h1111);
    check("f_we0h", fwd_hit[0], FWD);

    // reset mid-stream with hold on the last stage
    hold = 3'b100; in_valid = 1'b1; in_data = 55; reset = 1'b1;
    step();
    reset = 1'b0; hold = '0; in_valid = 1'b0; #1;
    check("t6_valid", st_valid, 0);
    check("t6_ret", retired, 0);
    check("t6_ready", in_ready, 1);
    check("t6_data", |st_data, 0);
    check("t6_we", st_we, 0);
    check("t6_rd", st_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
